// File: rtl/stack_master_pkg.sv
// stack_master_pkg: shared types and constants for the stack command initiator.
//   DATA_W_DEF           : default data width, must match the stack instance
//   CNT_W                : statistics counter width
//   OP_PUSH / OP_POP     : encoding of req_op and stk_operation
//   stack_master_state_t : command FSM states
package stack_master_pkg;

  localparam int   DATA_W_DEF = 16;
  localparam int   CNT_W      = 16;
  localparam logic OP_PUSH    = 1'b1;
  localparam logic OP_POP     = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    POP,
    POP_WAIT,
    RESP
  } stack_master_state_t;

endpackage

// File: rtl/stack_master_if.sv
// stack_master_if: request/response stream plus stack command port.
//   req_*  : request stream from the sequencer (valid/ready)
//   rsp_*  : response stream back to the sequencer (valid/ready)
//   stk_*  : strobe/data/flag port of the LIFO stack
// Modports: master = the stack_master block, slave = its environment
// (sequencer + stack).
interface stack_master_if #(
  parameter int DATA_W = 16
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              stk_enable;
  logic              stk_operation;
  logic [DATA_W-1:0] stk_data_in;
  logic [DATA_W-1:0] stk_data_out;
  logic              stk_full;
  logic              stk_empty;

  modport master (
    input  req_valid, req_op, req_data, rsp_ready,
    input  stk_data_out, stk_full, stk_empty,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output stk_enable, stk_operation, stk_data_in
  );

  modport slave (
    output req_valid, req_op, req_data, rsp_ready,
    output stk_data_out, stk_full, stk_empty,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  stk_enable, stk_operation, stk_data_in
  );

endinterface

// File: rtl/stack_stat_counter.sv
// stack_stat_counter: saturating event counter.
//   clk, rst : clock, async active-high reset
//   inc      : count one event this cycle
//   cnt      : current count, sticks at all-ones
module stack_stat_counter
  import stack_master_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (inc && (~cnt != 0)) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/stack_master.sv
// stack_master: turns a push/pop request stream into single-cycle stack
// strobes and returns one response per request (popped data or error).
// Illegal requests (push while full, pop while empty) are answered with
// rsp_err and never reach the stack.
//   clk, rst            : clock, async active-high reset
//   bus (master)        : req_*/rsp_* streams and stk_* command port
//   cnt_push/pop/err    : statistics, built only with STACK_MASTER_STATS_EN,
//                         otherwise tied to 0
module stack_master
  import stack_master_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  stack_master_if.master    bus,
  output logic [CNT_W-1:0]  cnt_push,
  output logic [CNT_W-1:0]  cnt_pop,
  output logic [CNT_W-1:0]  cnt_err
);

  stack_master_state_t state;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;
  logic              en_q;
  logic              op_q;
  logic [DATA_W-1:0] din_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      en_q        <= 1'b0;
      op_q        <= OP_POP;
      din_q       <= '0;
    end else begin
      // strobes last exactly one cycle
      en_q  <= 1'b0;
      op_q  <= OP_POP;
      din_q <= '0;
      case (state)
        IDLE: begin
          // ready comes up one clock after reset, then stays up in IDLE
          req_ready_q <= 1'b1;
          if (req_ready_q && bus.req_valid) begin
            req_ready_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            if (bus.req_op == OP_PUSH) begin
              if (bus.stk_full) begin
                state       <= RESP;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
              end else begin
                state <= PUSH;
                en_q  <= 1'b1;
                op_q  <= OP_PUSH;
                din_q <= bus.req_data;
              end
            end else begin
              if (bus.stk_empty) begin
                state       <= RESP;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
              end else begin
                state <= POP;
                en_q  <= 1'b1;
                op_q  <= OP_POP;
              end
            end
          end
        end
        PUSH: begin
          state       <= RESP;
          rsp_valid_q <= 1'b1;
        end
        POP: state <= POP_WAIT;
        POP_WAIT: begin
          // stack output is registered: valid one cycle after the pop strobe
          rsp_data_q  <= bus.stk_data_out;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.stk_enable    = en_q;
  assign bus.stk_operation = op_q;
  assign bus.stk_data_in   = din_q;

`ifdef STACK_MASTER_STATS_EN
  logic err_hit;
  // error counted on the same edge that moves the FSM into RESP
  assign err_hit = (state == IDLE) && req_ready_q && bus.req_valid &&
                   ((bus.req_op == OP_PUSH) ? bus.stk_full : bus.stk_empty);

  stack_stat_counter u_cnt_push (.clk(clk), .rst(rst), .inc(en_q &&  op_q), .cnt(cnt_push));
  stack_stat_counter u_cnt_pop  (.clk(clk), .rst(rst), .inc(en_q && !op_q), .cnt(cnt_pop));
  stack_stat_counter u_cnt_err  (.clk(clk), .rst(rst), .inc(err_hit),       .cnt(cnt_err));
`else
  assign cnt_push = '0;
  assign cnt_pop  = '0;
  assign cnt_err  = '0;
`endif

endmodule
